// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// Advances an (h_cnt, v_cnt) raster position on each pixel_tick and presents
// the registered decode of that position (sync levels, active-video flag,
// coordinates and start-of-line/frame strobes) one clk later.
module vga_sync_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  localparam int  H_TOTAL     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int  HW          = $clog2(H_TOTAL),
  localparam int  VW          = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          pixel_valid,
  output logic          line_start,
  output logic          frame_start
);

  // Per-axis raster region
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  // Counter values at which each region begins
  localparam logic [HW-1:0] H_FP_AT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SY_AT = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_BP_AT = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_FP_AT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SY_AT = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_BP_AT = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    h_st_q, h_st_d;
  logic [1:0]    v_st_q, v_st_d;
  logic          h_wrap, v_wrap;

  logic          hsync_q, vsync_q, video_on_q;
  logic [HW-1:0] x_q;
  logic [VW-1:0] y_q;
  logic          pixel_valid_q, line_start_q, frame_start_q;

  // Region the horizontal FSM enters when the counter moves to n
  function automatic logic [1:0] h_step(input logic [HW-1:0] n, input logic [1:0] s);
    logic [1:0] r;
    r = s;
    if (n == '0)           r = ST_ACTIVE;
    else if (n == H_FP_AT) r = ST_FRONT;
    else if (n == H_SY_AT) r = ST_SYNC;
    else if (n == H_BP_AT) r = ST_BACK;
    return r;
  endfunction

  // Region the vertical FSM enters when the line counter moves to n
  function automatic logic [1:0] v_step(input logic [VW-1:0] n, input logic [1:0] s);
    logic [1:0] r;
    r = s;
    if (n == '0)           r = ST_ACTIVE;
    else if (n == V_FP_AT) r = ST_FRONT;
    else if (n == V_SY_AT) r = ST_SYNC;
    else if (n == V_BP_AT) r = ST_BACK;
    return r;
  endfunction

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  // Next raster position and region; vertical only moves on line wrap
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_st_d  = h_st_q;
    v_st_d  = v_st_q;
    if (pixel_tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      h_st_d  = h_step(h_cnt_d, h_st_q);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        v_st_d  = v_step(v_cnt_d, v_st_q);
      end
    end
  end

  // Raster counters and region FSMs
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_st_q  <= ST_ACTIVE;
      v_st_q  <= ST_ACTIVE;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_st_q  <= h_st_d;
      v_st_q  <= v_st_d;
    end
  end

  // Output stage: latch the decode of the current position on each tick
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pixel_valid_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pixel_tick) begin
      hsync_q       <= (h_st_q == ST_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q       <= (v_st_q == ST_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_q    <= (h_st_q == ST_ACTIVE) && (v_st_q == ST_ACTIVE);
      x_q           <= h_cnt_q;
      y_q           <= v_cnt_q;
      pixel_valid_q <= 1'b1;
      line_start_q  <= (h_cnt_q == '0);
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end else begin
      pixel_valid_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = pixel_valid_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen on a reduced raster
// (32 x 13 total) so that whole frames fit in a short run.
module tb_vga_sync_gen;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pixel_tick = 1'b0;
  logic          hsync, vsync, video_on;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          pixel_valid, line_start, frame_start;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .pixel_valid(pixel_valid),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: p is the linear index of the next pixel in the frame
  int   p = 0;
  int   e_x = 0, e_y = 0;
  logic e_von = 1'b0, e_hs = 1'b1, e_vs = 1'b1;
  logic e_pv = 1'b0, e_ls = 1'b0, e_fs = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic t);
    if (r) begin
      p = 0; e_x = 0; e_y = 0;
      e_von = 0; e_hs = 1; e_vs = 1; e_pv = 0; e_ls = 0; e_fs = 0;
    end else if (t) begin
      e_x   = p % HT;
      e_y   = p / HT;
      e_von = (e_x < HA) && (e_y < VA);
      e_hs  = !((e_x >= HA + HF) && (e_x < HA + HF + HS));
      e_vs  = !((e_y >= VA + VF) && (e_y < VA + VF + VS));
      e_pv  = 1; e_ls = (e_x == 0); e_fs = (p == 0);
      p     = (p + 1) % FRAME;
    end else begin
      e_pv = 0; e_ls = 0; e_fs = 0;
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({x, y, video_on, hsync, vsync, pixel_valid, line_start, frame_start});
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [HW-1:0] ex;
    logic [VW-1:0] ey;
    ex = HW'(e_x);
    ey = VW'(e_y);
    return 32'({ex, ey, e_von, e_hs, e_vs, e_pv, e_ls, e_fs});
  endfunction

  // One clk: drive on the falling edge, sample 1 time unit after rising edge
  task automatic cyc(input logic r, input logic t, input bit cmp);
    @(negedge clk);
    reset = r;
    pixel_tick = t;
    @(posedge clk);
    model(r, t);
    #1;
    if (cmp) chk("model", dut_vec(), exp_vec());
  endtask

  typedef struct {
    logic r, t;
    int   x, y;
    logic von, hs, vs, pv, ls, fs;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int cnt, vlow, hlow;
    bit started, found;

    // Directed table: reset state, first pixel, hold, reset-vs-tick priority
    tbl[0] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    tbl[3] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    tbl[5] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    tbl[7] = '{0, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].r, tbl[i].t, 0);
      chk($sformatf("tbl%0d_x", i),   32'(x),        32'(tbl[i].x));
      chk($sformatf("tbl%0d_y", i),   32'(y),        32'(tbl[i].y));
      chk($sformatf("tbl%0d_von", i), 32'(video_on), 32'(tbl[i].von));
      chk($sformatf("tbl%0d_hs", i),  32'(hsync),    32'(tbl[i].hs));
      chk($sformatf("tbl%0d_vs", i),  32'(vsync),    32'(tbl[i].vs));
      chk($sformatf("tbl%0d_pv", i),  32'(pixel_valid), 32'(tbl[i].pv));
      chk($sformatf("tbl%0d_ls", i),  32'(line_start),  32'(tbl[i].ls));
      chk($sformatf("tbl%0d_fs", i),  32'(frame_start), 32'(tbl[i].fs));
    end

    // Tick every 4th clk for a line plus one pixel; count hsync-low ticks
    cyc(1, 0, 1);
    hlow = 0;
    for (int i = 0; i <= HT; i++) begin
      cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
      cyc(0, 1, 1);
      if (i < HT && !hsync) hlow++;
      if (i == HA) chk("von_fall", 32'(video_on), 0);
      if (i == HT) begin
        chk("wrap_x", 32'(x), 0);
        chk("wrap_y", 32'(y), 1);
        chk("wrap_ls", 32'(line_start), 1);
      end
    end
    chk("hsync_width", 32'(hlow), 32'(HS));

    // Pause ticks mid-line: everything holds, strobes stay low
    found = 0;
    for (int i = 0; i < 4 * HT && !found; i++) begin
      cyc(0, 1, 1);
      if (e_x == 10) found = 1;
    end
    chk("find_x10", 32'(found), 1);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1);
    chk("hold_x", 32'(x), 10);
    chk("hold_pv", 32'(pixel_valid), 0);
    cyc(0, 1, 1);
    chk("hold_next_x", 32'(x), 11);

    // Reset while both syncs are asserted
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      cyc(0, 1, 1);
      if (e_x == HA + HF + 1 && e_y == VA + VF + 1) found = 1;
    end
    chk("find_sync", 32'(found), 1);
    chk("in_sync_hs", 32'(hsync), 0);
    chk("in_sync_vs", 32'(vsync), 0);
    cyc(1, 0, 1);
    chk("rst_hs", 32'(hsync), 1);
    chk("rst_vs", 32'(vsync), 1);
    chk("rst_von", 32'(video_on), 0);
    chk("rst_xy", 32'({x, y}), 0);
    cyc(0, 1, 1);
    chk("post_rst_fs", 32'(frame_start), 1);

    // Reset and tick in the same clk
    cyc(1, 1, 1);
    chk("rst_tick_pv", 32'(pixel_valid), 0);

    // Continuous ticks over a whole frame
    cyc(1, 0, 1);
    started = 0; found = 0; cnt = 0; vlow = 0;
    for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
      cyc(0, 1, 1);
      if (frame_start && started) begin
        found = 1;
        chk("frame_wrap_xy", 32'({x, y}), 0);
      end else begin
        if (frame_start) started = 1;
        if (started && pixel_valid) begin
          cnt++;
          if (!vsync) vlow++;
        end
      end
    end
    chk("frame_seen", 32'(found), 1);
    chk("frame_len", 32'(cnt), 32'(FRAME));
    chk("vsync_len", 32'(vlow), 32'(VS * HT));

    // Randomized ticks and occasional resets against the model
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parameterised VGA raster timing generator that consumes the single-cycle `pixel_tick` enable from the pixel-clock divider and produces registered hsync/vsync, the active-video flag and the current raster coordinates for the downstream pixel/convolution pipeline. It runs entirely in the `clk` domain; `pixel_tick` is its only rate control. Default parameters give 640x480 @ 60 Hz timing: 800x525 total, on a 25 MHz tick.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BACK, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, level of hsync/vsync during the sync pulse (0 = active-low)
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_tick  in  1  one-clk enable; advances the raster by one pixel
- hsync  out  1  horizontal sync, level per SYNC_ACTIVE
- vsync  out  1  vertical sync, level per SYNC_ACTIVE
- video_on  out  1  high when the presented pixel is inside H_ACTIVE x V_ACTIVE
- x  out  HW  horizontal position of the presented pixel, 0..H_TOTAL-1
- y  out  VW  vertical position of the presented pixel, 0..V_TOTAL-1
- pixel_valid  out  1  one-clk strobe: a new pixel position was presented this cycle
- line_start  out  1  one-clk strobe coincident with pixel_valid when x==0
- frame_start  out  1  one-clk strobe coincident with pixel_valid when x==0 and y==0

## Operation
- Internal counters h_cnt (HW bits) and v_cnt (VW bits), both reset to 0.
- Per-axis FSM, states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Horizontal transitions occur on h_cnt boundaries H_ACTIVE, H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC, and H_TOTAL (wrap). Vertical transitions occur on the same boundaries of v_cnt and advance only on horizontal wrap. Both FSMs reset to ACTIVE.
- On a clk edge with pixel_tick=1, the output stage loads the decode of the current (h_cnt, v_cnt):
  - x=h_cnt, y=v_cnt
  - video_on = both FSMs in ACTIVE
  - hsync = SYNC_ACTIVE iff horizontal FSM is in SYNC (h_cnt in [656,751] by default)
  - vsync = SYNC_ACTIVE iff vertical FSM is in SYNC (v_cnt in [490,491] by default)
  - pixel_valid=1; line_start/frame_start as defined above
- On the same edge the counters advance:
  - h_cnt = H_TOTAL-1 wraps to 0 and v_cnt increments
  - v_cnt = V_TOTAL-1 with h_cnt = H_TOTAL-1 wraps both to 0
- On a clk edge with pixel_tick=0: counters, FSMs, x, y, video_on, hsync and vsync hold their values; pixel_valid, line_start and frame_start are 0.
- Reset values: hsync=vsync=~SYNC_ACTIVE, video_on=0, x=0, y=0, pixel_valid=0, line_start=0, frame_start=0.
- Reset has priority over pixel_tick. Reset asserted mid-frame returns to the reset state on the next edge. The first tick after reset presents (0,0) with frame_start=1.
- Continuous pixel_tick=1 is legal: one pixel per clk, with no gaps or skipped coordinates.

## Timing
- Latency: outputs reflect the counter state at the tick edge, visible 1 clk after the edge where pixel_tick was sampled high.
- Strobes are exactly 1 clk wide regardless of tick spacing.
- One line = H_TOTAL ticks; one frame = H_TOTAL*V_TOTAL ticks (420000 by default).
- hsync low for exactly H_SYNC consecutive ticks per line. vsync low for exactly V_SYNC*H_TOTAL ticks per frame, starting at x=0 of line V_ACTIVE+V_FRONT.
- All outputs are registered; no combinational path from pixel_tick to any output.

## Test plan
- Reset, then pixel_tick every 4th clk. First pixel_valid shows x=0, y=0, video_on=1, frame_start=1, line_start=1, hsync=vsync=1.
- Tick every 4th clk for one line. video_on falls at x=640. hsync=0 for x=656..751 (96 ticks). x=799 is followed by x=0, y=1, line_start=1.
- Run a full frame with continuous pixel_tick=1. 420000 pixel_valid strobes between frame_start pulses. vsync=0 only for y=490..491 (1600 ticks). y=524, x=799 wraps to (0,0).
- Hold pixel_tick=0 for 50 clks mid-line at x=300. All outputs hold, strobes stay 0, and the next tick presents x=301.
- Assert reset for 1 clk at x=700, y=491 (both syncs active). The next edge shows hsync=vsync=1, video_on=0, x=y=0. The next tick presents (0,0) with frame_start=1.
- Assert reset and pixel_tick in the same clk. Reset wins: outputs equal the reset values and pixel_valid=0.
